// File: rtl/vram_access_arbiter.sv
// vram_access_arbiter: shares one single-port VRAM between beam-locked video fetches and a CPU handshake port,
// with a saturating counter of CPU cycles lost to video slots.
module vram_access_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int H_ACTIVE   = 256,
  parameter int V_ACTIVE   = 240,
  parameter int FETCH_LOG2 = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    shpos,
  input  logic [9:0]    svpos,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   stall_cnt
);
  typedef enum logic {S_IDLE, S_ACK} state_t;
  state_t        r_state, w_next;
  logic          r_vid_pend;
  logic [DW-1:0] r_vid_data;
  logic [AW-1:0] r_ram_addr;
  logic [15:0]   r_stall;
  logic          w_vslot, w_cpu_issue, w_blocked;
  always_comb begin
    w_vslot     = shpos[FETCH_LOG2-1:0] == '0 && shpos < 10'(H_ACTIVE) && svpos < 10'(V_ACTIVE);
    w_cpu_issue = r_state == S_IDLE && cpu_req && !w_vslot && !reset;
    w_blocked   = r_state == S_IDLE && cpu_req && w_vslot;
    w_next      = w_cpu_issue ? S_ACK : S_IDLE;
    ram_we      = w_cpu_issue && cpu_we;
    ram_addr    = w_vslot ? vid_addr : w_cpu_issue ? cpu_addr : r_ram_addr;
    ram_wdata   = cpu_wdata;
    cpu_ack     = r_state == S_ACK && !reset;
    cpu_rdata   = cpu_ack ? ram_rdata : '0;
    vid_valid   = r_vid_pend && !reset;
    vid_data    = vid_valid ? ram_rdata : r_vid_data;
    stall_cnt   = r_stall;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_vid_pend <= 1'b0;
      r_vid_data <= '0;
      r_stall    <= '0;
    end else begin
      r_state    <= w_next;
      r_vid_pend <= w_vslot;
      r_vid_data <= vid_valid ? ram_rdata : r_vid_data;
      r_stall    <= (w_blocked && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall;
    end
  end
  // Idle cycles keep the previous address on the RAM pins to avoid needless toggling.
  always_ff @(posedge clk) r_ram_addr <= ram_addr;
endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb_vram_access_arbiter: directed and random CPU/video traffic checked every cycle against a
// cycle-level model derived from the arbitration rules, plus targeted latency/count checks.
module tb_vram_access_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  shpos = '0, svpos = 10'd250;
  logic [15:0] vid_addr = '0, cpu_addr = '0, ram_addr;
  logic [7:0]  vid_data, cpu_wdata = '0, cpu_rdata, ram_wdata, ram_rdata;
  logic        vid_valid, cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack, ram_we;
  logic [15:0] stall_cnt;
  bit   [7:0]  ram [65536];
  bit   [7:0]  ref_mem [65536];
  int          checks = 0, errors = 0;
  bit          m_ack = 0, m_ack_rd = 0, m_vpend = 0;
  logic [7:0]  m_ack_data = '0, m_vnext = '0, m_vhold = '0;
  int          m_stall = 0;
  bit          run_beam = 0, rand_vid = 0, got_ack = 0;
  logic [7:0]  last_rdata = '0;
  int          we_count = 0, vcount = 0;
  vram_access_arbiter dut (
    .clk(clk), .reset(reset), .shpos(shpos), .svpos(svpos),
    .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One clock: inputs are already stable (driven at negedge); check, advance model, step to next negedge.
  task automatic tick();
    bit vs, iss;
    vs  = (shpos % 8 == 0) && shpos < 256 && svpos < 240;
    iss = !reset && !m_ack && cpu_req && !vs;
    #1;
    chk("ram_we", ram_we, iss && cpu_we);
    if (!reset && (vs || iss)) chk("ram_addr", ram_addr, vs ? vid_addr : cpu_addr);
    if (iss && cpu_we) chk("ram_wdata", ram_wdata, cpu_wdata);
    chk("cpu_ack", cpu_ack, m_ack && !reset);
    if (m_ack && !reset && m_ack_rd) chk("cpu_rdata", cpu_rdata, m_ack_data);
    chk("vid_valid", vid_valid, m_vpend && !reset);
    chk("vid_data", vid_data, (m_vpend && !reset) ? m_vnext : m_vhold);
    chk("stall_cnt", stall_cnt, m_stall);
    got_ack = cpu_ack;
    last_rdata = cpu_rdata;
    if (ram_we) we_count++;
    if (vid_valid) vcount++;
    m_vhold = reset ? 8'h00 : (m_vpend ? m_vnext : m_vhold);
    if (reset) m_stall = 0;
    else if (!m_ack && cpu_req && vs && m_stall < 65535) m_stall++;
    m_vpend = vs && !reset;
    if (vs) m_vnext = ref_mem[vid_addr];
    if (iss) begin
      m_ack_rd = !cpu_we;
      m_ack_data = ref_mem[cpu_addr];
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    end
    m_ack = iss;
    @(posedge clk);
    @(negedge clk);
    if (run_beam) shpos = (shpos == 10'd340) ? 10'd0 : shpos + 10'd1;
    if (rand_vid) vid_addr = 16'h0200 + 16'($urandom_range(0, 15));
  endtask
  task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                            input bit hold, output int n, output logic [7:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n = 0; got_ack = 0;
    while (!got_ack && n < 40) begin
      tick();
      n++;
    end
    chk("ack_timeout", got_ack, 1);
    rd = last_rdata;
    if (!hold) cpu_req = 1'b0;
  endtask
  initial begin
    int n;
    logic [7:0] rd;
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    chk("rst_ack", cpu_ack, 0);
    chk("rst_valid", vid_valid, 0);
    chk("rst_vdata", vid_data, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_stall", stall_cnt, 0);
    reset = 1'b0;
    cpu_access(1'b1, 16'h1234, 8'hA5, 0, n, rd);
    cpu_access(1'b0, 16'h1234, 8'h00, 0, n, rd);
    chk("blank_lat", n, 2);
    chk("blank_rd", rd, 8'hA5);
    chk("blank_stall", stall_cnt, 0);
    svpos = 10'd10; shpos = 10'd16; vid_addr = 16'h1234; run_beam = 1;
    cpu_access(1'b1, 16'h0040, 8'h3C, 0, n, rd);
    chk("coll_lat", n, 3);
    chk("coll_stall", stall_cnt, 1);
    run_beam = 0; svpos = 10'd250;
    cpu_access(1'b0, 16'h0040, 8'h00, 0, n, rd);
    chk("coll_rd", rd, 8'h3C);
    we_count = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_access(1'b1, 16'h0100 + 16'(i), 8'h50 + 8'(i), i < 2, n, rd);
      chk("b2b_spacing", n, 2);
    end
    tick();
    chk("b2b_we_count", we_count, 3);
    svpos = 10'd0; shpos = 10'd0; run_beam = 1; rand_vid = 1; vcount = 0;
    repeat (301) tick();
    chk("sweep_pulses", vcount, 32);
    for (int i = 0; i < 200; i++) begin
      svpos = 10'($urandom_range(0, 260));
      shpos = 10'($urandom_range(0, 340));
      cpu_access(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 15)),
                 8'($urandom), 0, n, rd);
      repeat ($urandom_range(0, 3)) tick();
    end
    run_beam = 0; rand_vid = 0; svpos = 10'd0; shpos = 10'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h77;
    repeat (70000) tick();
    chk("sat_stall", stall_cnt, 16'hFFFF);
    svpos = 10'd250;
    cpu_access(1'b1, 16'h0300, 8'h77, 0, n, rd);
    chk("sat_lat", n, 2);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    tick();
    reset = 1'b1; cpu_we = 1'b1;
    tick();
    chk("rst_mid_ack", got_ack, 0);
    tick();
    chk("rst_mid_stall", stall_cnt, 0);
    reset = 1'b0; cpu_req = 1'b0;
    tick();
    chk("rst_post_ack", cpu_ack, 0);
    chk("rst_post_mem", ram[16'h0040], 8'h3C);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
